// File: rtl/seq_alu_hs.sv
// seq_alu_hs: registered ALU with valid/ready flow control on both sides.
// Single-cycle ops (AND/ADD/OR/XOR/SUB/SLT, and illegal 111) produce their
// result one cycle after acceptance. MUL is unsigned shift-add, one step per
// cycle over WIDTH cycles, with the full 2*WIDTH product split across
// result_hi/result.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. Input side: in_ready is high only in IDLE, and operands are taken
// at the accepting edge. Output side: out_valid and every result/flag output
// hold steady in DONE until out_ready is seen, and the block then returns to
// IDLE. It cannot accept a new op in that same cycle.
module seq_alu_hs #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             err,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     a_q;
  logic [2*WIDTH-1:0]   prod;

  logic [WIDTH:0]       add_w;
  logic [WIDTH:0]       sub_w;
  logic [WIDTH-1:0]     c_res;
  logic                 c_carry;
  logic                 c_ovf;
  logic                 c_err;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;

  assign in_ready  = (state == IDLE);
  assign state_dbg = state;

  // Single-cycle datapath evaluated on the live operands at the accept edge.
  always_comb begin
    add_w   = {1'b0, a} + {1'b0, b};
    sub_w   = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    c_res   = '0;
    c_carry = 1'b0;
    c_ovf   = 1'b0;
    c_err   = 1'b0;
    case (op)
      OP_AND: c_res = a & b;
      OP_ADD: begin
        c_res   = add_w[WIDTH-1:0];
        c_carry = add_w[WIDTH];
        c_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_OR:  c_res = a | b;
      OP_XOR: c_res = a ^ b;
      OP_SUB: begin
        c_res   = sub_w[WIDTH-1:0];
        // carry-out of a + ~b + 1 is "no borrow", so invert it
        c_carry = ~sub_w[WIDTH];
        c_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: c_res = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
      OP_MUL: c_res = '0;
      default: c_err = 1'b1;
    endcase
  end

  // One shift-add step: conditionally add the multiplicand into the upper
  // half, then shift the whole product right (multiplier bits drain out low).
  always_comb begin
    mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_q} : '0);
    mul_next = {mul_sum, prod[WIDTH-1:1]};
  end

  // Control FSM with registered result and flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      a_q       <= '0;
      prod      <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (op == OP_MUL) begin
              a_q   <= a;
              prod  <= {{WIDTH{1'b0}}, b};
              cnt   <= '0;
              state <= BUSY;
            end else begin
              result    <= c_res;
              result_hi <= '0;
              zero      <= (c_res == '0);
              carry     <= c_carry;
              ovf       <= c_ovf;
              err       <= c_err;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        BUSY: begin
          prod <= mul_next;
          if (cnt == LAST_STEP) begin
            cnt       <= '0;
            result    <= mul_next[WIDTH-1:0];
            result_hi <= mul_next[2*WIDTH-1:WIDTH];
            zero      <= (mul_next == '0);
            carry     <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
